// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life control sequencer.
// Provides the sequencer state encoding, default grid sizes and a clamp helper.
package life_pkg;

    localparam int COORD_W_DEF = 8;
    localparam int GRID_W_DEF  = 160;
    localparam int GRID_H_DEF  = 120;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_X    = 4'd1,
        WAIT_Y    = 4'd2,
        LOAD_Y    = 4'd3,
        PLOT      = 4'd4,
        PLOT_WAIT = 4'd5,
        READY     = 4'd6,
        RUN_WAIT  = 4'd7,
        GEN       = 4'd8,
        GEN_WAIT  = 4'd9
    } state_t;

    // Saturate v at lim. Works on 32-bit values so one helper
    // serves any coordinate width up to 32 bits.
    function automatic logic [31:0] clamp(
        input logic [31:0] v,
        input logic [31:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/life_sequencer_edge_rise.sv
// Button rise detector: one-cycle pulse on a 0->1 level change.
// Ports: clock, reset (sync, active-low), d (button level), rise (pulse).
module edge_rise (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Reset loads 1 so a button held through reset never fires.
    always_ff @(posedge clock) begin
        if (!reset) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/life_sequencer.sv
// Game of Life control sequencer: cell placement, free-run/step generations.
// Ports: clock/reset, buttons set/go/step/stop, load_val, datapath handshakes
//        plot_done/gen_done in, x_out/y_out/plot_req/gen_start/running/gen_count out.
module life_sequencer
    import life_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEF,
    parameter int GRID_W   = GRID_W_DEF,
    parameter int GRID_H   = GRID_H_DEF,
    parameter int GEN_W    = 16,
    parameter int TICK_DIV = 12_500_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               set,
    input  logic               go,
    input  logic               step,
    input  logic               stop,
    input  logic [COORD_W-1:0] load_val,
    input  logic               plot_done,
    input  logic               gen_done,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic               plot_req,
    output logic               gen_start,
    output logic               running,
    output logic [GEN_W-1:0]   gen_count
);

    localparam int TW = $clog2(TICK_DIV + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [31:0]   X_MAX     = 32'(GRID_W - 1);
    localparam logic [31:0]   Y_MAX     = 32'(GRID_H - 1);

    state_t        state;
    logic [TW-1:0] tick;
    logic          single;
    logic          stop_pending;

    logic set_r;
    logic go_r;
    logic step_r;
    logic stop_r;

    edge_rise u_set (
        .clock (clock),
        .reset (reset),
        .d     (set),
        .rise  (set_r)
    );

    edge_rise u_go (
        .clock (clock),
        .reset (reset),
        .d     (go),
        .rise  (go_r)
    );

    edge_rise u_step (
        .clock (clock),
        .reset (reset),
        .d     (step),
        .rise  (step_r)
    );

    edge_rise u_stop (
        .clock (clock),
        .reset (reset),
        .d     (stop),
        .rise  (stop_r)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            x_out        <= '0;
            y_out        <= '0;
            gen_count    <= '0;
            tick         <= '0;
            single       <= 1'b0;
            stop_pending <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (set_r) begin
                        state <= LOAD_X;
                    end
                end
                LOAD_X: begin
                    x_out <= COORD_W'(clamp(32'(load_val), X_MAX));
                    state <= WAIT_Y;
                end
                WAIT_Y: begin
                    if (set_r) begin
                        state <= LOAD_Y;
                    end
                end
                LOAD_Y: begin
                    y_out <= COORD_W'(clamp(32'(load_val), Y_MAX));
                    state <= PLOT;
                end
                PLOT: begin
                    state <= PLOT_WAIT;
                end
                PLOT_WAIT: begin
                    if (plot_done) begin
                        single       <= 1'b0;
                        stop_pending <= 1'b0;
                        state        <= READY;
                    end
                end
                READY: begin
                    if (set_r) begin
                        gen_count <= '0;
                        state     <= LOAD_X;
                    end else if (go_r) begin
                        state <= RUN_WAIT;
                    end else if (step_r) begin
                        single <= 1'b1;
                        state  <= GEN;
                    end
                end
                RUN_WAIT: begin
                    // A stop wins over a tick landing on the same cycle.
                    if (stop_r) begin
                        tick         <= '0;
                        single       <= 1'b0;
                        stop_pending <= 1'b0;
                        state        <= READY;
                    end else if (tick == TICK_LAST) begin
                        tick  <= '0;
                        state <= GEN;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                GEN: begin
                    if (stop_r) begin
                        stop_pending <= 1'b1;
                    end
                    state <= GEN_WAIT;
                end
                GEN_WAIT: begin
                    // The generation always finishes; a stop only
                    // decides where we go once it has.
                    if (gen_done) begin
                        gen_count <= gen_count + 1'b1;
                        if (single || stop_pending || stop_r) begin
                            single       <= 1'b0;
                            stop_pending <= 1'b0;
                            state        <= READY;
                        end else begin
                            state <= RUN_WAIT;
                        end
                    end else if (stop_r) begin
                        stop_pending <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign plot_req  = (state == PLOT);
    assign gen_start = (state == GEN);
    assign running   = (state == RUN_WAIT) ||
                       (state == GEN) ||
                       (state == GEN_WAIT);

endmodule

// File: tb/tb_life_sequencer.sv
// Scoreboard bench for life_sequencer: placement, held buttons, free-run,
// stop, single-step with counter wrap and reset during a generation.
module tb_life_sequencer;
    import life_pkg::*;

    localparam int CW = 8;
    localparam int GW = 160;
    localparam int GH = 120;
    localparam int NW = 4;
    localparam int TD = 4;

    typedef struct {
        int c;
        int x;
        int y;
    } plot_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          set   = 1'b0;
    logic          go    = 1'b0;
    logic          step  = 1'b0;
    logic          stop  = 1'b0;
    logic [CW-1:0] load_val = '0;
    logic          plot_done;
    logic          gen_done;
    logic [CW-1:0] x_out;
    logic [CW-1:0] y_out;
    logic          plot_req;
    logic          gen_start;
    logic          running;
    logic [NW-1:0] gen_count;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int loadx_seen = 0;
    int a = 0;

    logic [3:0] gs_sr = '0;
    logic [1:0] pd_sr = '0;
    logic       man_done = 1'b0;

    int    gs_q[$];
    plot_t pl_q[$];

    life_sequencer #(
        .COORD_W  (CW),
        .GRID_W   (GW),
        .GRID_H   (GH),
        .GEN_W    (NW),
        .TICK_DIV (TD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .set       (set),
        .go        (go),
        .step      (step),
        .stop      (stop),
        .load_val  (load_val),
        .plot_done (plot_done),
        .gen_done  (gen_done),
        .x_out     (x_out),
        .y_out     (y_out),
        .plot_req  (plot_req),
        .gen_start (gen_start),
        .running   (running),
        .gen_count (gen_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Datapath model: gen_done lands 3 cycles after gen_start is taken,
    // plot_done one cycle after plot_req is taken.
    always @(posedge clock) begin
        gs_sr <= {gs_sr[2:0], gen_start};
        pd_sr <= {pd_sr[0], plot_req};
    end

    assign gen_done  = gs_sr[3] | man_done;
    assign plot_done = pd_sr[1];

    task automatic chk(
        input string       tag,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_st(
        input string  tag,
        input state_t s,
        input int     budget
    );
        int k;
        k = 0;
        while (dut.state !== s && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(dut.state), 32'(s));
    endtask

    // Output side of the scoreboard.
    always @(negedge clock) begin
        if (dut.state == LOAD_X) loadx_seen <= loadx_seen + 1;
        if (gen_start === 1'b1) begin
            if (gs_q.size() == 0) begin
                chk("gs_unexp", 32'(gen_start), 32'd0);
            end else begin
                chk("gs_cyc", cyc, gs_q[0]);
                void'(gs_q.pop_front());
            end
        end
        if (plot_req === 1'b1) begin
            if (pl_q.size() == 0) begin
                chk("pl_unexp", 32'(plot_req), 32'd0);
            end else begin
                chk("pl_cyc", cyc, pl_q[0].c);
                chk("pl_x", 32'(x_out), pl_q[0].x);
                chk("pl_y", 32'(y_out), pl_q[0].y);
                void'(pl_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with set held high through reset.
        set = 1'b1;
        ticks(3);
        chk("rst_st", 32'(dut.state), 32'(IDLE));
        chk("rst_x", 32'(x_out), 0);
        chk("rst_y", 32'(y_out), 0);
        chk("rst_cnt", 32'(gen_count), 0);
        chk("rst_outs", {29'd0, plot_req, gen_start, running}, 0);
        reset = 1'b1;
        tick();
        chk("rst_hold", 32'(dut.state), 32'(IDLE));
        set = 1'b0;
        tick();

        // Held set: one LOAD_X only, x clamped from 200.
        set = 1'b1;
        load_val = 8'd200;
        ticks(5);
        load_val = 8'd120;
        ticks(5);
        chk("held_x", 32'(x_out), 159);
        chk("held_lx", loadx_seen, 1);
        chk("held_st", 32'(dut.state), 32'(WAIT_Y));
        set = 1'b0;
        tick();

        // y entry and plot handshake.
        load_val = 8'd50;
        set = 1'b1;
        pl_q.push_back('{cyc + 2, 159, 50});
        tick();
        set = 1'b0;
        wait_st("pl_ready", READY, 10);
        chk("pl_ystab", 32'(y_out), 50);

        // Free-run: first gen_start 5 cycles after the rise, then every 9.
        a = cyc;
        go = 1'b1;
        gs_q.push_back(a + 5);
        gs_q.push_back(a + 14);
        gs_q.push_back(a + 23);
        tick();
        go = 1'b0;
        ticks(9);
        chk("fr_cnt1", 32'(gen_count), 1);
        ticks(9);
        chk("fr_cnt2", 32'(gen_count), 2);
        chk("fr_run", 32'(running), 1);

        // Stop during GEN_WAIT: generation still completes.
        ticks(6);
        chk("st_gw", 32'(dut.state), 32'(GEN_WAIT));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        ticks(2);
        chk("st_cnt", 32'(gen_count), 3);
        chk("st_st", 32'(dut.state), 32'(READY));
        chk("st_run", 32'(running), 0);
        ticks(20);
        chk("st_quiet", gs_q.size(), 0);

        // set from READY clears the count; y clamps at 119.
        load_val = 8'd5;
        set = 1'b1;
        tick();
        set = 1'b0;
        tick();
        chk("sc_cnt", 32'(gen_count), 0);
        chk("sc_x", 32'(x_out), 5);
        load_val = 8'd130;
        set = 1'b1;
        pl_q.push_back('{cyc + 2, 5, 119});
        tick();
        set = 1'b0;
        wait_st("sc_ready", READY, 10);
        chk("sc_y", 32'(y_out), 119);

        // 17 single steps wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            a = cyc;
            step = 1'b1;
            gs_q.push_back(a + 1);
            tick();
            step = 1'b0;
            wait_st("sp_ready", READY, 12);
            chk("sp_run", 32'(running), 0);
        end
        chk("sp_cnt", 32'(gen_count), 1);

        // Reset inside GEN_WAIT, then late done pulses.
        a = cyc;
        step = 1'b1;
        gs_q.push_back(a + 1);
        tick();
        step = 1'b0;
        tick();
        chk("rr_gw", 32'(dut.state), 32'(GEN_WAIT));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        ticks(4);
        chk("rr_st", 32'(dut.state), 32'(IDLE));
        chk("rr_cnt", 32'(gen_count), 0);
        chk("rr_xy", {16'd0, x_out, y_out}, 0);
        chk("rr_outs", {29'd0, plot_req, gen_start, running}, 0);

        chk("gs_left", gs_q.size(), 0);
        chk("pl_left", pl_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/life_sequencer.md
# life_sequencer

Parametrised top-level control sequencer for the Game of Life board, sitting between the user push-buttons/switches and the grid datapath. It places cells by coordinate entry through a plot handshake with the datapath, and runs generations either free-running at a divided rate or one at a time. It keeps a generation counter. Unlike the first-generation control FSM, it edge-detects buttons, clamps coordinates to the grid, waits for datapath completion instead of assuming fixed latency, and never aborts a generation mid-update.

## Interface
Parameters:
- COORD_W, 8, width of the coordinate bus and x/y registers
- GRID_W, 160, grid columns; x is clamped to GRID_W-1
- GRID_H, 120, grid rows; y is clamped to GRID_H-1
- GEN_W, 16, generation counter width
- TICK_DIV, 12_500_000, clock cycles per free-running generation (must be ≥1)

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-low reset
- set  in  1  coordinate-entry button, active-high level
- go  in  1  start free-run button, active-high level
- step  in  1  single-generation button, active-high level
- stop  in  1  stop button, active-high level
- load_val  in  COORD_W  coordinate value from switches
- plot_done  in  1  datapath finished writing the cell at x_out/y_out
- gen_done  in  1  datapath finished computing one generation
- x_out  out  COORD_W  latched, clamped x coordinate
- y_out  out  COORD_W  latched, clamped y coordinate
- plot_req  out  1  one-cycle request to write a live cell
- gen_start  out  1  one-cycle request to compute a generation
- running  out  1  high in RUN_WAIT, GEN and GEN_WAIT
- gen_count  out  GEN_W  completed generations, wraps modulo 2^GEN_W

## Operation
- Each button goes through a rise detector: rise = btn & ~btn_q. A held button acts once.
- States: IDLE, LOAD_X, WAIT_Y, LOAD_Y, PLOT, PLOT_WAIT, READY, RUN_WAIT, GEN, GEN_WAIT.
- IDLE: set rise goes to LOAD_X.
- LOAD_X: latch x_out = min(load_val, GRID_W-1) and go to WAIT_Y.
- WAIT_Y: set rise goes to LOAD_Y.
- LOAD_Y: latch y_out = min(load_val, GRID_H-1) and go to PLOT.
- PLOT: plot_req=1 for one cycle, then go to PLOT_WAIT.
- PLOT_WAIT: plot_done goes to READY. All button rises are ignored here.
- READY: priority is set > go > step.
  - set rise: clear gen_count, go to LOAD_X.
  - go rise: go to RUN_WAIT.
  - step rise: set single=1, go to GEN.
  - stop rise: no effect.
- RUN_WAIT: tick counter counts 0..TICK_DIV-1.
  - At TICK_DIV-1, go to GEN.
  - A stop rise goes to READY immediately and takes priority over the tick.
- GEN: gen_start=1 for one cycle, then go to GEN_WAIT.
- GEN_WAIT: on gen_done, gen_count += 1 (wraps). Then:
  - go to READY if single or stop_pending;
  - otherwise go to RUN_WAIT.
- stop_pending is set by a stop rise in GEN or GEN_WAIT and cleared on entering READY. A generation is never aborted.
- single is cleared on entering READY.
- The tick counter is zero whenever the state is not RUN_WAIT. It is COORD-independent with width $clog2(TICK_DIV+1).
- A gen_done or plot_done outside its wait state is ignored.

## Timing
- Reset, checked on the clock edge while reset==0:
  - state = IDLE; x_out, y_out, gen_count, tick counter, single, stop_pending = 0.
  - Button _q registers load 1, so a button held through reset does not produce a rise.
  - All outputs are low.
- Reset mid-operation (including GEN_WAIT) has the same effect. Any later datapath done pulse is ignored.
- Outputs plot_req, gen_start and running are Moore, decoded from the registered state.
- Button rise at edge N puts the next state in effect at edge N+1.
- go rise to first gen_start: RUN_WAIT lasts exactly TICK_DIV cycles, so gen_start goes high TICK_DIV+1 cycles after the rise is sampled.
- Free-run period is TICK_DIV + 2 + (gen_done latency) cycles.
- gen_count updates on the same edge as the GEN_WAIT exit.
- x_out/y_out change only at LOAD_X/LOAD_Y and are stable through PLOT_WAIT.

## Structure
- life_pkg: state enum (4-bit), default GRID_W/GRID_H/COORD_W constants, and a clamp function.
- One sub-module, edge_rise (clock, reset, d, rise), instantiated four times for set/go/step/stop.
- The FSM, tick counter and generation counter live in life_sequencer.

## Test plan
Bench parameters: TICK_DIV=4, GRID_W=160, GRID_H=120, COORD_W=8, GEN_W=4.

- **Placement:** set pulse, load_val=200; then set pulse, load_val=50 → x_out=159, y_out=50; one-cycle plot_req; READY after plot_done.
- **Held button:** set held for 10 cycles in IDLE → exactly one LOAD_X; x_out latched once.
- **Free-run:** go rise in READY, with gen_done returned 3 cycles after each gen_start → gen_start 5 cycles after the rise, then every 9 cycles; gen_count 0→1→2.
- **Stop mid-generation:** stop rise during GEN_WAIT → generation completes, gen_count increments, state READY, no further gen_start.
- **Step and wrap:** step ×17 from READY with gen_count=0 → 17 gen_start pulses, running low after each, gen_count=1 (wrap at 16).
- **Reset mid-run:** reset low in GEN_WAIT, then gen_done asserted → all outputs 0, state IDLE, gen_count stays 0.
